// File: rtl/cerere_pietoni_pkg.sv
// Shared types and default constants for the pedestrian request conditioner.
package cerere_pietoni_pkg;

  typedef enum logic [1:0] {
    LIBER  = 2'd0,
    CERERE = 2'd1,
    SERVIT = 2'd2
  } stare_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 3;
  localparam int unsigned BLINK_HALF_DEF      = 2;
  localparam int unsigned CNT_W_DEF           = 8;

  // Width of a counter that must hold values 0..max_val-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser and stability debouncer for the pedestrian push-button.
module debounce_sync
  import cerere_pietoni_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic buton_raw,
  output logic stabil,
  output logic apasare
);

  localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("debounce_sync: DEBOUNCE_CYCLES must be in 1..255");
  end

  logic       sync_meta;
  logic       sync;
  logic       stabil_prev;
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta   <= 1'b0;
      sync        <= 1'b0;
      stabil      <= 1'b0;
      stabil_prev <= 1'b0;
      cnt         <= 8'd0;
    end else begin
      sync_meta   <= buton_raw;
      sync        <= sync_meta;
      stabil_prev <= stabil;
      // Any cycle where sync agrees with stabil restarts the stability window.
      if (sync != stabil) begin
        if (cnt == LIMIT - 8'd1) begin
          stabil <= sync;
          cnt    <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

  assign apasare = stabil & ~stabil_prev;

endmodule

// File: rtl/cerere_pietoni.sv
// Pedestrian request latch, wait indicator and request counter.
// Optional blinking indicator enabled by defining CERERE_BLINK_EN.
module cerere_pietoni
  import cerere_pietoni_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned BLINK_HALF      = BLINK_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             buton_raw,
  input  logic             pietoni_verde,
  output logic             buton_pietoni,
  output logic             indicator_asteptare,
  output logic [CNT_W-1:0] nr_cereri
);

  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("cerere_pietoni: BLINK_HALF must be at least 1");
  end

  logic   stabil_unused;
  logic   apasare;
  stare_t stare;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .buton_raw(buton_raw),
    .stabil   (stabil_unused),
    .apasare  (apasare)
  );

`ifdef CERERE_BLINK_EN
  localparam int unsigned BW = cnt_width(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt;
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_HALF;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stare               <= LIBER;
      buton_pietoni       <= 1'b0;
      indicator_asteptare <= 1'b0;
      nr_cereri           <= '0;
`ifdef CERERE_BLINK_EN
      blink_cnt           <= '0;
`endif
    end else begin
      unique case (stare)
        LIBER: begin
          // A press while walk is already showing is simply dropped.
          if (apasare && !pietoni_verde) begin
            stare               <= CERERE;
            buton_pietoni       <= 1'b1;
            indicator_asteptare <= 1'b1;
            nr_cereri           <= nr_cereri + CNT_W'(1);
`ifdef CERERE_BLINK_EN
            blink_cnt           <= '0;
`endif
          end
        end
        CERERE: begin
          if (pietoni_verde) begin
            stare               <= SERVIT;
            buton_pietoni       <= 1'b0;
            indicator_asteptare <= 1'b0;
          end else begin
`ifdef CERERE_BLINK_EN
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt           <= '0;
              indicator_asteptare <= ~indicator_asteptare;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
`else
            indicator_asteptare <= 1'b1;
`endif
          end
        end
        SERVIT: begin
          if (!pietoni_verde) begin
            stare <= LIBER;
          end
        end
        default: begin
          stare               <= LIBER;
          buton_pietoni       <= 1'b0;
          indicator_asteptare <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cerere_pietoni.sv
// Randomised and directed bench for cerere_pietoni against a behavioural request model.
module tb_cerere_pietoni;

  localparam int unsigned D  = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned BH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          buton_raw;
  logic          pietoni_verde;
  logic          buton_pietoni;
  logic          indicator_asteptare;
  logic [CW-1:0] nr_cereri;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cerere_pietoni #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW),
    .BLINK_HALF     (BH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .buton_raw          (buton_raw),
    .pietoni_verde      (pietoni_verde),
    .buton_pietoni      (buton_pietoni),
    .indicator_asteptare(indicator_asteptare),
    .nr_cereri          (nr_cereri)
  );

  // Model: raw delay line, run length of disagreement, pending/walk flags.
  int m_s1, m_s2, m_st, m_stp, m_run, m_k, m_cnt;
  bit m_pend, m_walk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_ind();
    if (!m_pend) return 0;
`ifdef CERERE_BLINK_EN
    return ((m_k / BH) % 2 == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_st = 0; m_stp = 0; m_run = 0; m_k = 0; m_cnt = 0;
    m_pend = 0; m_walk = 0;
  endtask

  task automatic model_step();
    bit press;
    press = (m_st == 1) && (m_stp == 0);
    if (m_pend) begin
      if (pietoni_verde) begin
        m_pend = 0;
        m_walk = 1;
      end else begin
        m_k++;
      end
    end else if (m_walk) begin
      if (!pietoni_verde) m_walk = 0;
    end else if (press && !pietoni_verde) begin
      m_pend = 1;
      m_k    = 0;
      m_cnt  = (m_cnt + 1) % (1 << CW);
    end
    m_stp = m_st;
    if (m_s2 != m_st) begin
      m_run++;
      if (m_run == int'(D)) begin
        m_st  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(buton_raw);
  endtask

  // Drive inputs after a falling edge, advance one rising edge, check on the next falling edge.
  task automatic cycle(input logic raw, input logic pv);
    buton_raw     = raw;
    pietoni_verde = pv;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("req", int'(buton_pietoni), int'(m_pend));
    check_eq("ind", int'(indicator_asteptare), exp_ind());
    check_eq("cnt", int'(nr_cereri), m_cnt);
  endtask

  initial begin
    int pv_hold;
    int seg;
    logic raw_r;
    logic pv_r;

    rst = 1'b1;
    buton_raw = 1'b0;
    pietoni_verde = 1'b0;
    model_reset();
    #1;
    check_eq("rst_req", int'(buton_pietoni), 0);
    check_eq("rst_ind", int'(indicator_asteptare), 0);
    check_eq("rst_cnt", int'(nr_cereri), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean press latency and indicator pattern.
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 5) check_eq("lat5_req", int'(buton_pietoni), 0);
      if (i == 6) begin
        check_eq("lat6_req", int'(buton_pietoni), 1);
        check_eq("lat6_cnt", int'(nr_cereri), 1);
      end
      if (i >= 6) begin
`ifdef CERERE_BLINK_EN
        check_eq("blink", int'(indicator_asteptare), (((i - 6) / 2) % 2 == 0) ? 1 : 0);
`else
        check_eq("steady", int'(indicator_asteptare), 1);
`endif
      end
    end

    // Service handshake with re-press during walk.
    for (int i = 1; i <= 10; i++) begin
      cycle((i <= 4) ? 1'b0 : 1'b1, 1'b1);
      check_eq("walk_req", int'(buton_pietoni), 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    check_eq("srv_cnt", int'(nr_cereri), 1);
    check_eq("srv_req", int'(buton_pietoni), 0);
    check_eq("srv_liber", int'(dut.stare), 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);

    // Press while walk already active is dropped.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    check_eq("walk_press_cnt", int'(nr_cereri), 1);
    check_eq("walk_press_req", int'(buton_pietoni), 0);

    // Bounce: pulses and gaps of 1..2 cycles never qualify.
    for (int i = 0; i < 12; i++) begin
      seg = int'($urandom_range(1, 2));
      for (int j = 0; j < seg; j++) cycle(1'b1, 1'b0);
      seg = int'($urandom_range(1, 2));
      for (int j = 0; j < seg; j++) cycle(1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
    check_eq("bounce_req", int'(buton_pietoni), 0);
    check_eq("bounce_cnt", int'(nr_cereri), 1);

    // Asynchronous reset while a request is pending.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    check_eq("pre_rst_req", int'(buton_pietoni), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_req", int'(buton_pietoni), 0);
    check_eq("arst_ind", int'(indicator_asteptare), 0);
    check_eq("arst_cnt", int'(nr_cereri), 0);
    model_reset();
    buton_raw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

    // Counter wrap after 2^CW accepted requests.
    for (int n = 0; n < (1 << CW); n++) begin
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
      if (n == (1 << CW) - 1) check_eq("cnt_max", int'(nr_cereri), 0);
      if (n == (1 << CW) - 2) check_eq("cnt_255", int'(nr_cereri), (1 << CW) - 1);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
    end
    check_eq("wrap_cnt", int'(nr_cereri), 0);

    // Random traffic with a controller that grants after a random delay.
    pv_hold = 0;
    seg = 0;
    raw_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (seg == 0) begin
        raw_r = ~raw_r;
        seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2))
                                          : int'($urandom_range(3, 12));
      end
      seg--;
      if (pv_hold > 0) begin
        pv_r = 1'b1;
        pv_hold--;
      end else begin
        pv_r = 1'b0;
        if (m_pend && ($urandom_range(0, 3) == 0)) pv_hold = int'($urandom_range(1, 8));
        else if (!m_pend && ($urandom_range(0, 39) == 0)) pv_hold = int'($urandom_range(1, 5));
      end
      cycle(raw_r, pv_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
